fc_dllp_scheduler: RTL and testbench

- Sequences Flow Control DLLP transmission on the receive side of the link.
- Runs PCIe-style flow-control initialisation: an InitFC1 round, then an InitFC2 round, for each of the P, NP and Cpl credit types.
- After initialisation, owns the per-type CREDITS_ALLOCATED counters, accumulates credits freed by the RX buffer, and arbitrates UpdateFC DLLPs round-robin among the three types.
- Sits between the RX buffer release interface and the DLLP transmit packer.

---
 rtl/fc_pkg.sv | 35 +++
 rtl/fc_rr_arb3.sv | 37 +++
 rtl/fc_dllp_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_fc_dllp_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared flow-control types: credit types, DLLP kinds, credit widths and the
// {type, hdr, data} credit record used by the allocator and the DLLP scheduler.
package fc_pkg;

  localparam int HDR_W  = 8;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  typedef enum logic [1:0] {
    DLLP_INITFC1  = 2'd0,
    DLLP_INITFC2  = 2'd1,
    DLLP_UPDATEFC = 2'd2
  } dllp_kind_e;

  typedef struct packed {
    fc_type_e            ctype;
    logic [HDR_W-1:0]    hdr;
    logic [DATA_W-1:0]   data;
  } fc_credit_t;

  // P -> NP -> Cpl -> P
  function automatic logic [1:0] fc_next_type(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

  function automatic logic [1:0] fc_onehot_idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/fc_rr_arb3.sv
// Three-way round-robin arbiter: the search starts just after the last
// accepted grant; P wins first after reset.
module fc_rr_arb3
  import fc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic [2:0] i_pend,
  input  logic       i_accept,
  output logic [2:0] o_grant
);

  logic [1:0] r_last;
  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_idx;

  assign w_c0 = fc_next_type(r_last);
  assign w_c1 = fc_next_type(w_c0);

  always_comb begin
    w_idx = r_last;
    if (i_pend[w_c0])      w_idx = w_c0;
    else if (i_pend[w_c1]) w_idx = w_c1;
    o_grant = (|i_pend) ? (3'b001 << w_idx) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_last <= 2'd2;
    end else if (i_accept && (|i_pend)) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/fc_dllp_scheduler.sv
// Receive-side flow-control DLLP scheduler: InitFC1/InitFC2 rounds, then
// credit accumulation and round-robin UpdateFC issue toward the DLLP packer.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | link down; counters at initial values, nothing sent
//   S_INIT1  | InitFC1 rounds P/NP/Cpl until partner InitFC1 seen
//   S_INIT2  | InitFC2 rounds P/NP/Cpl until partner InitFC2/UpdateFC seen
//   S_ACTIVE | accumulate released credits, UpdateFC on change or refresh
module fc_dllp_scheduler
  import fc_pkg::*;
#(
  parameter logic [7:0]  INIT_PH    = 8'd32,
  parameter logic [11:0] INIT_PD    = 12'd512,
  parameter logic [7:0]  INIT_NPH   = 8'd32,
  parameter logic [7:0]  INIT_CPLH  = 8'd32,
  parameter logic [11:0] INIT_CPLD  = 12'd512,
  parameter logic [15:0] UPD_PERIOD = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up_i,
  input  logic        rmt_init1_i,
  input  logic        rmt_init2_i,
  input  logic        rel_valid_i,
  input  logic [1:0]  rel_type_i,
  input  logic [7:0]  rel_hdr_i,
  input  logic [11:0] rel_data_i,
  output logic        dllp_valid_o,
  input  logic        dllp_ready_i,
  output logic [1:0]  dllp_kind_o,
  output logic [1:0]  dllp_type_o,
  output logic [7:0]  dllp_hdr_o,
  output logic [11:0] dllp_data_o,
  output logic        dl_active_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INIT1  = 2'd1;
  localparam logic [1:0] S_INIT2  = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_tp;
  logic              r_init1_seen;
  logic              r_init2_seen;
  logic [HDR_W-1:0]  r_hdr  [3];
  logic [DATA_W-1:0] r_data [3];
  logic [2:0]        r_pend;
  logic              r_newer;
  logic [15:0]       r_timer;
  logic              r_valid;
  logic [1:0]        r_kind;
  fc_credit_t        r_dllp;
  logic              r_active;

  logic              w_clr;
  logic              w_hs;
  logic              w_rel;
  logic              w_tc;
  logic              w_init;
  logic              w_launch;
  logic              w_seen1;
  logic              w_seen2;
  logic [2:0]        w_grant;
  logic [1:0]        w_ltype;
  logic [1:0]        w_lkind;
  fc_credit_t        w_payload;
  logic [2:0]        w_pend_nxt;

  assign w_clr    = !rst_n || !link_up_i;
  assign w_hs     = r_valid && dllp_ready_i;
  assign w_rel    = rel_valid_i && (r_state == S_ACTIVE) && (rel_type_i != 2'd3);
  assign w_tc     = (r_state == S_ACTIVE) && (r_timer == 16'd0);
  assign w_init   = (r_state == S_INIT1) || (r_state == S_INIT2);
  assign w_launch = !r_valid && (w_init || ((r_state == S_ACTIVE) && (|w_grant)));
  assign w_seen1  = r_init1_seen || rmt_init1_i;
  assign w_seen2  = r_init2_seen || rmt_init2_i;
  assign w_ltype  = w_init ? r_tp : fc_onehot_idx(w_grant);
  assign w_lkind  = (r_state == S_INIT1) ? DLLP_INITFC1 :
                    (r_state == S_INIT2) ? DLLP_INITFC2 : DLLP_UPDATEFC;

  fc_rr_arb3 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!link_up_i),
    .i_pend   (r_pend),
    .i_accept (w_launch && (r_state == S_ACTIVE)),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_payload.ctype = fc_type_e'(w_ltype);
    w_payload.hdr   = r_hdr[w_ltype];
    w_payload.data  = (w_ltype == FC_NP) ? '0 : r_data[w_ltype];
  end

  // A release that lands while its type is in flight keeps the bit set so the
  // newer count goes out again.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_tc) w_pend_nxt = 3'b111;
    if (w_hs && (r_state == S_ACTIVE)) w_pend_nxt[r_dllp.ctype] = r_newer;
    if (w_rel) w_pend_nxt[rel_type_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state      <= S_IDLE;
      r_tp         <= FC_P;
      r_init1_seen <= 1'b0;
      r_init2_seen <= 1'b0;
      r_hdr[0]     <= INIT_PH;
      r_hdr[1]     <= INIT_NPH;
      r_hdr[2]     <= INIT_CPLH;
      r_data[0]    <= INIT_PD;
      r_data[1]    <= '0;
      r_data[2]    <= INIT_CPLD;
      r_pend       <= '0;
      r_newer      <= 1'b0;
      r_timer      <= UPD_PERIOD - 16'd1;
      r_valid      <= 1'b0;
      r_kind       <= '0;
      r_dllp       <= '0;
      r_active     <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        if (rmt_init1_i) r_init1_seen <= 1'b1;
        if (rmt_init2_i) r_init2_seen <= 1'b1;
      end

      if (w_rel) begin
        r_hdr[rel_type_i] <= r_hdr[rel_type_i] + rel_hdr_i;
        if (rel_type_i != FC_NP) r_data[rel_type_i] <= r_data[rel_type_i] + rel_data_i;
      end

      r_pend <= w_pend_nxt;

      if (r_state == S_ACTIVE) r_timer <= w_tc ? (UPD_PERIOD - 16'd1) : (r_timer - 16'd1);

      if (w_launch) begin
        r_newer <= 1'b0;
      end else if (r_valid && !w_hs && w_rel && (rel_type_i == r_dllp.ctype)) begin
        r_newer <= 1'b1;
      end

      if (w_hs) begin
        r_valid <= 1'b0;
      end else if (w_launch) begin
        r_valid <= 1'b1;
        r_kind  <= w_lkind;
        r_dllp  <= w_payload;
      end

      case (r_state)
        S_IDLE: begin
          r_state <= S_INIT1;
          r_tp    <= FC_P;
        end
        S_INIT1, S_INIT2: begin
          if (w_hs) begin
            if (r_tp == FC_CPL) begin
              r_tp <= FC_P;
              if ((r_state == S_INIT1) && w_seen1) begin
                r_state <= S_INIT2;
              end else if ((r_state == S_INIT2) && w_seen2) begin
                r_state  <= S_ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              r_tp <= fc_next_type(r_tp);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dllp_valid_o = r_valid;
  assign dllp_kind_o  = r_kind;
  assign dllp_type_o  = r_dllp.ctype;
  assign dllp_hdr_o   = r_dllp.hdr;
  assign dllp_data_o  = r_dllp.data;
  assign dl_active_o  = r_active;

endmodule

// File: tb/tb_fc_dllp_scheduler.sv
// Directed-plus-random bench for fc_dllp_scheduler; advertised credits are
// compared against a per-type running-sum model of released credits.
module tb_fc_dllp_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up_i;
  logic        rmt_init1_i;
  logic        rmt_init2_i;
  logic        rel_valid_i;
  logic [1:0]  rel_type_i;
  logic [7:0]  rel_hdr_i;
  logic [11:0] rel_data_i;
  logic        dllp_valid_o;
  logic        dllp_ready_i;
  logic [1:0]  dllp_kind_o;
  logic [1:0]  dllp_type_o;
  logic [7:0]  dllp_hdr_o;
  logic [11:0] dllp_data_o;
  logic        dl_active_o;

  fc_dllp_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_up_i    (link_up_i),
    .rmt_init1_i  (rmt_init1_i),
    .rmt_init2_i  (rmt_init2_i),
    .rel_valid_i  (rel_valid_i),
    .rel_type_i   (rel_type_i),
    .rel_hdr_i    (rel_hdr_i),
    .rel_data_i   (rel_data_i),
    .dllp_valid_o (dllp_valid_o),
    .dllp_ready_i (dllp_ready_i),
    .dllp_kind_o  (dllp_kind_o),
    .dllp_type_o  (dllp_type_o),
    .dllp_hdr_o   (dllp_hdr_o),
    .dllp_data_o  (dllp_data_o),
    .dl_active_o  (dl_active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [1:0]  ctype;
    logic [7:0]  hdr;
    logic [11:0] data;
    int          at;
  } obs_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          model_on = 1'b0;
  logic        prev_valid = 1'b0;
  logic [23:0] held = '0;
  int          m_hdr [3];
  int          m_data [3];
  int          last_hdr [3];
  int          last_data [3];
  obs_t        obs [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock: capture inputs, sample outputs after the edge, log launches,
  // verify held payloads and fold this cycle's release into the model.
  task automatic tick();
    logic        hs;
    logic        rv;
    logic [1:0]  rt;
    logic [7:0]  rh;
    logic [11:0] rd;
    obs_t        o;
    hs = dllp_valid_o && dllp_ready_i;
    rv = rel_valid_i;
    rt = rel_type_i;
    rh = rel_hdr_i;
    rd = rel_data_i;
    @(posedge clk);
    #1;
    cyc++;
    if (dllp_valid_o && prev_valid && !hs)
      check("held_payload", 32'({dllp_kind_o, dllp_type_o, dllp_hdr_o, dllp_data_o}), 32'(held));
    if (dllp_valid_o && (!prev_valid || hs)) begin
      o.kind  = dllp_kind_o;
      o.ctype = dllp_type_o;
      o.hdr   = dllp_hdr_o;
      o.data  = dllp_data_o;
      o.at    = cyc;
      obs.push_back(o);
      if (dllp_type_o == 2'd1) check("np_data_zero", 32'(dllp_data_o), 32'd0);
      if (model_on && (dllp_kind_o == 2'd2) && (dllp_type_o != 2'd3)) begin
        check("upd_hdr_vs_model", 32'(dllp_hdr_o), m_hdr[dllp_type_o]);
        check("upd_data_vs_model", 32'(dllp_data_o), m_data[dllp_type_o]);
        last_hdr[dllp_type_o]  = int'(dllp_hdr_o);
        last_data[dllp_type_o] = int'(dllp_data_o);
      end
    end
    if (model_on && rv && (rt != 2'd3)) begin
      m_hdr[rt] = (m_hdr[rt] + int'(rh)) % 256;
      if (rt != 2'd1) m_data[rt] = (m_data[rt] + int'(rd)) % 4096;
    end
    prev_valid = dllp_valid_o;
    held = {dllp_kind_o, dllp_type_o, dllp_hdr_o, dllp_data_o};
  endtask

  task automatic rel(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    rel_valid_i = 1'b1;
    rel_type_i  = t;
    rel_hdr_i   = h;
    rel_data_i  = d;
    tick();
    rel_valid_i = 1'b0;
  endtask

  task automatic wait_launch(input int maxc, input string tag);
    int n0;
    int k;
    n0 = obs.size();
    k = 0;
    while (obs.size() == n0 && k < maxc) begin
      tick();
      k++;
    end
    check({tag, "_launched"}, 32'(obs.size() > n0), 32'd1);
  endtask

  task automatic wait_count(input int n, input int maxc, input string tag);
    int k;
    k = 0;
    while (obs.size() < n && k < maxc) begin
      tick();
      k++;
    end
    check({tag, "_count"}, 32'(obs.size() >= n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int a_cyc;
    int n0;
    int d;
    int wrap_exp [4];
    wrap_exp = '{96, 160, 224, 32};

    rst_n = 1'b0;
    link_up_i = 1'b0;
    rmt_init1_i = 1'b0;
    rmt_init2_i = 1'b0;
    rel_valid_i = 1'b0;
    rel_type_i = 2'd0;
    rel_hdr_i = '0;
    rel_data_i = '0;
    dllp_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(dllp_valid_o), 32'd0);
    check("rst_fields", 32'({dllp_kind_o, dllp_type_o, dllp_hdr_o, dllp_data_o}), 32'd0);
    check("rst_active", 32'(dl_active_o), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("linkdown_idle_valid", 32'(dllp_valid_o), 32'd0);

    // No partner: InitFC1 rounds repeat
    dllp_ready_i = 1'b1;
    link_up_i = 1'b1;
    repeat (40) tick();
    check("nopartner_rounds", 32'(obs.size() >= 12), 32'd1);
    for (int i = 0; i < obs.size(); i++) begin
      check("nopartner_kind", 32'(obs[i].kind), 32'd0);
      check("nopartner_type", 32'(obs[i].ctype), 32'(i % 3));
    end
    check("nopartner_active", 32'(dl_active_o), 32'd0);
    link_up_i = 1'b0;
    tick();
    tick();
    obs.delete();

    // Full init handshake
    link_up_i = 1'b1;
    repeat (3) tick();
    rmt_init1_i = 1'b1;
    tick();
    rmt_init1_i = 1'b0;
    wait_count(4, 30, "init_first4");
    rmt_init2_i = 1'b1;
    tick();
    rmt_init2_i = 1'b0;
    begin
      int k;
      k = 0;
      while (!dl_active_o && k < 40) begin
        tick();
        k++;
      end
    end
    check("init_dl_active", 32'(dl_active_o), 32'd1);
    a_cyc = cyc;
    check("init_dllp_count", 32'(obs.size()), 32'd6);
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      check("init_kind", 32'(obs[i].kind), (i < 3) ? 32'd0 : 32'd1);
      check("init_type", 32'(obs[i].ctype), 32'(i % 3));
      check("init_hdr", 32'(obs[i].hdr), 32'd32);
      check("init_data", 32'(obs[i].data), (i % 3 == 1) ? 32'd0 : 32'd512);
    end

    m_hdr  = '{32, 32, 32};
    m_data = '{512, 0, 512};
    last_hdr  = '{32, 32, 32};
    last_data = '{512, 0, 512};
    model_on = 1'b1;

    // Header wrap on P
    for (int i = 0; i < 4; i++) begin
      rel(2'd0, 8'd64, 12'd0);
      wait_launch(10, "wrap");
      check("wrap_hdr", 32'(obs[$].hdr), 32'(wrap_exp[i]));
      check("wrap_type", 32'(obs[$].ctype), 32'd0);
      tick();
    end

    // Update with a stalled packer and a release during the stall
    dllp_ready_i = 1'b0;
    rel(2'd0, 8'd3, 12'd16);
    tick();
    check("latency_valid", 32'(dllp_valid_o), 32'd1);
    check("upd_kind", 32'(dllp_kind_o), 32'd2);
    check("upd_p_hdr", 32'(dllp_hdr_o), 32'd35);
    check("upd_p_data", 32'(dllp_data_o), 32'd528);
    tick();
    rel(2'd0, 8'd1, 12'd0);
    tick();
    tick();
    check("stall_hdr", 32'(dllp_hdr_o), 32'd35);
    dllp_ready_i = 1'b1;
    tick();
    wait_launch(10, "upd_after_stall");
    check("upd2_type", 32'(obs[$].ctype), 32'd0);
    check("upd2_hdr", 32'(obs[$].hdr), 32'd36);
    check("upd2_data", 32'(obs[$].data), 32'd528);
    tick();

    // Round-robin across back-to-back releases
    n0 = obs.size();
    rel(2'd0, 8'd2, 12'd8);
    rel(2'd1, 8'd5, 12'd7);
    rel(2'd2, 8'd1, 12'd1);
    wait_count(n0 + 3, 20, "rr");
    for (int i = 0; i < 3 && (n0 + i) < obs.size(); i++) begin
      check("rr_order", 32'(obs[n0 + i].ctype), 32'(i));
      check("rr_kind", 32'(obs[n0 + i].kind), 32'd2);
    end
    repeat (3) tick();

    // Periodic refresh with no releases
    n0 = obs.size();
    wait_count(n0 + 3, 1200, "timer");
    if (obs.size() > n0) begin
      d = obs[n0].at - a_cyc;
      check("timer_phase_in_window", 32'(d >= 1022 && d <= 1028), 32'd1);
    end
    for (int i = 0; i < 3 && (n0 + i) < obs.size(); i++)
      check("timer_order", 32'(obs[n0 + i].ctype), 32'(i));
    tick();

    // Randomised releases and back-pressure against the model
    repeat (1500) begin
      rel_valid_i  = ($urandom_range(0, 9) < 3);
      rel_type_i   = 2'($urandom_range(0, 3));
      rel_hdr_i    = 8'($urandom_range(0, 255));
      rel_data_i   = 12'($urandom_range(0, 4095));
      dllp_ready_i = ($urandom_range(0, 9) < 7);
      tick();
    end
    rel_valid_i = 1'b0;
    dllp_ready_i = 1'b1;
    repeat (30) tick();
    for (int t = 0; t < 3; t++) begin
      check("final_hdr", 32'(last_hdr[t]), 32'(m_hdr[t]));
      check("final_data", 32'(last_data[t]), 32'(m_data[t]));
    end

    // Link drop during a stall, then re-initialise
    dllp_ready_i = 1'b0;
    rel(2'd2, 8'd4, 12'd4);
    wait_launch(10, "ld_launch");
    tick();
    link_up_i = 1'b0;
    model_on = 1'b0;
    tick();
    check("ld_valid", 32'(dllp_valid_o), 32'd0);
    check("ld_active", 32'(dl_active_o), 32'd0);
    tick();
    link_up_i = 1'b1;
    dllp_ready_i = 1'b1;
    n0 = obs.size();
    wait_count(n0 + 3, 20, "reinit");
    if (obs.size() >= n0 + 3) begin
      check("reinit_kind", 32'(obs[n0].kind), 32'd0);
      check("reinit_type", 32'(obs[n0].ctype), 32'd0);
      check("reinit_p_hdr", 32'(obs[n0].hdr), 32'd32);
      check("reinit_p_data", 32'(obs[n0].data), 32'd512);
      check("reinit_cpl_hdr", 32'(obs[n0 + 2].hdr), 32'd32);
      check("reinit_cpl_data", 32'(obs[n0 + 2].data), 32'd512);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
